// File: rtl/t07_memory_handler.sv
// Load/store stage: turns control-unit memory requests into a single-outstanding
// data-bus transaction, steers byte lanes, checks alignment, extends load data
// and feeds the register-file write port. freeze_o stalls the datapath meanwhile.
module t07_memory_handler #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] alu_result,
  input  logic        reg_write_i,
  input  logic [4:0]  rd_i,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_strb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] write_data,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic        freeze_o,
  output logic        access_err_o,
  output logic        bus_err_o
);

  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [7:0]  tmo_cnt_q;
  logic [31:0] load_result_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [4:0]  rd_q;
  logic        is_load_q;

  logic        mem_op;
  logic        is_load;
  logic        funct3_legal;
  logic        misaligned;
  logic        req_ok;
  logic [3:0]  strb_st;
  logic [31:0] wdata_st;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Request decode: legality of the access type and natural alignment.
  always_comb begin
    mem_op  = mem_read | mem_write;
    is_load = mem_read;  // a load wins when both strobes are set
    case (funct3)
      3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
      3'b100, 3'b101:         funct3_legal = is_load;  // unsigned forms exist only for loads
      default:                funct3_legal = 1'b0;
    endcase
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    req_ok = mem_op & funct3_legal & ~misaligned;
  end

  // Store lane steering: replicate data across lanes and enable the addressed bytes.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        strb_st  = 4'b0001 << addr[1:0];
        wdata_st = {4{store_data[7:0]}};
      end
      2'b01: begin
        strb_st  = addr[1] ? 4'b1100 : 4'b0011;
        wdata_st = {2{store_data[15:0]}};
      end
      default: begin
        strb_st  = 4'b1111;
        wdata_st = store_data;
      end
    endcase
  end

  // Load lane selection and sign/zero extension from the latched request.
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = bus_rdata;
    endcase
  end

  // Transaction FSM with registered bus outputs and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= 32'd0;
      bus_wdata     <= 32'd0;
      bus_strb      <= 4'd0;
      load_result_q <= 32'd0;
      tmo_cnt_q     <= 8'd0;
      funct3_q      <= 3'd0;
      lane_q        <= 2'd0;
      rd_q          <= 5'd0;
      is_load_q     <= 1'b0;
      access_err_o  <= 1'b0;
      bus_err_o     <= 1'b0;
    end else begin
      access_err_o <= 1'b0;
      bus_err_o    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (mem_op) begin
            if (!req_ok) begin
              access_err_o <= 1'b1;
            end else begin
              funct3_q  <= funct3;
              lane_q    <= addr[1:0];
              rd_q      <= rd_i;
              is_load_q <= is_load;
              bus_req   <= 1'b1;
              bus_we    <= ~is_load;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wdata <= wdata_st;
              bus_strb  <= is_load ? 4'b1111 : strb_st;
              tmo_cnt_q <= 8'd0;
              state_q   <= StBusy;
            end
          end
        end
        StBusy: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (is_load_q) begin
              load_result_q <= load_ext;
            end
            state_q <= StDone;
          end else if (tmo_cnt_q == TmoLast) begin
            // Abort: drop the request and return without writeback.
            bus_req   <= 1'b0;
            bus_err_o <= 1'b1;
            state_q   <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Writeback and stall outputs: pass-through when idle, latched values afterwards.
  always_comb begin
    write_data = alu_result;
    reg_write  = reg_write_i;
    write_reg  = rd_i;
    freeze_o   = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_op) begin
          reg_write = 1'b0;
          freeze_o  = req_ok;
        end
      end
      StBusy: begin
        reg_write = 1'b0;
        write_reg = rd_q;
        freeze_o  = 1'b1;
      end
      StDone: begin
        write_reg  = rd_q;
        write_data = load_result_q;
        reg_write  = is_load_q;
      end
      default: begin
        reg_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_t07_memory_handler.sv
// Directed bench for t07_memory_handler: loads, stores, access errors,
// bus timeout and mid-transaction reset.
module tb_t07_memory_handler;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] alu_result;
  logic        reg_write_i;
  logic [4:0]  rd_i;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strb;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] write_data;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic        freeze_o;
  logic        access_err_o;
  logic        bus_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  t07_memory_handler #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .alu_result   (alu_result),
    .reg_write_i  (reg_write_i),
    .rd_i         (rd_i),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_strb     (bus_strb),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .write_data   (write_data),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .freeze_o     (freeze_o),
    .access_err_o (access_err_o),
    .bus_err_o    (bus_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [31:0] exp_addr, input logic [31:0] exp);
    tick();
    mem_read = 1'b1; funct3 = f3; addr = a; rd_i = rd; reg_write_i = 1'b1;
    mid();
    chk({tag, "_frz_req"}, freeze_o, 1);
    chk({tag, "_rw_req"}, reg_write, 0);
    tick();
    mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = rdata;
    mid();
    chk({tag, "_bus_req"}, bus_req, 1);
    chk({tag, "_bus_addr"}, bus_addr, exp_addr);
    chk({tag, "_strb"}, bus_strb, 4'b1111);
    chk({tag, "_we"}, bus_we, 0);
    tick();
    bus_ack = 1'b0; bus_rdata = 32'd0;
    mid();
    chk({tag, "_wdata"}, write_data, exp);
    chk({tag, "_rw_done"}, reg_write, 1);
    chk({tag, "_wreg"}, write_reg, rd);
    chk({tag, "_frz_done"}, freeze_o, 0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    tick();
    mem_write = 1'b1; funct3 = f3; addr = a; store_data = sdata; reg_write_i = 1'b1;
    mid();
    chk({tag, "_frz_req"}, freeze_o, 1);
    tick();
    mem_write = 1'b0; bus_ack = 1'b1;
    mid();
    chk({tag, "_bus_req"}, bus_req, 1);
    chk({tag, "_we"}, bus_we, 1);
    chk({tag, "_bus_addr"}, bus_addr, exp_addr);
    chk({tag, "_strb"}, bus_strb, exp_strb);
    chk({tag, "_bus_wdata"}, bus_wdata, exp_wdata);
    tick();
    bus_ack = 1'b0;
    mid();
    chk({tag, "_rw_done"}, reg_write, 0);
    chk({tag, "_frz_done"}, freeze_o, 0);
  endtask

  task automatic do_err(input string tag, input logic is_store, input logic [2:0] f3,
                        input logic [31:0] a);
    tick();
    mem_read = ~is_store; mem_write = is_store; funct3 = f3; addr = a; reg_write_i = 1'b1;
    mid();
    chk({tag, "_frz"}, freeze_o, 0);
    chk({tag, "_rw"}, reg_write, 0);
    tick();
    mem_read = 1'b0; mem_write = 1'b0; reg_write_i = 1'b0;
    mid();
    chk({tag, "_err_pulse"}, access_err_o, 1);
    chk({tag, "_no_req"}, bus_req, 0);
    tick();
    mid();
    chk({tag, "_err_clear"}, access_err_o, 0);
    chk({tag, "_no_req2"}, bus_req, 0);
  endtask

  initial begin
    int req_cycles;
    int err_pulses;
    int rw_seen;
    int frz_cycles;

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; addr = 32'd0;
    store_data = 32'd0; alu_result = 32'd0; reg_write_i = 1'b0; rd_i = 5'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    tick();
    tick();
    mid();
    chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_strb", bus_strb, 0);
    chk("rst_aerr", access_err_o, 0);
    chk("rst_berr", bus_err_o, 0);
    chk("rst_frz", freeze_o, 0);
    tick();
    rst = 1'b0;

    // LW with ack on the second BUSY cycle; freeze spans request + 2 BUSY cycles.
    frz_cycles = 0;
    tick();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h100; rd_i = 5'd5; reg_write_i = 1'b1;
    mid();
    if (freeze_o) frz_cycles++;
    tick();
    mem_read = 1'b0;
    mid();
    if (freeze_o) frz_cycles++;
    chk("lw_bus_addr", bus_addr, 32'h100);
    chk("lw_strb", bus_strb, 4'b1111);
    chk("lw_req1", bus_req, 1);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    mid();
    if (freeze_o) frz_cycles++;
    chk("lw_req2", bus_req, 1);
    tick();
    bus_ack = 1'b0; bus_rdata = 32'd0;
    mid();
    if (freeze_o) frz_cycles++;
    chk("lw_wdata", write_data, 32'hDEADBEEF);
    chk("lw_rw", reg_write, 1);
    chk("lw_wreg", write_reg, 5'd5);
    chk("lw_req_drop", bus_req, 0);
    chk("lw_frz_cycles", frz_cycles, 3);

    do_load("lb",  3'b000, 32'h203, 32'h80FF1234, 5'd6, 32'h200, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h203, 32'h80FF1234, 5'd7, 32'h200, 32'h00000080);
    do_load("lh",  3'b001, 32'h202, 32'h80FF1234, 5'd8, 32'h200, 32'hFFFF80FF);
    do_load("lhu", 3'b101, 32'h202, 32'h80FF1234, 5'd9, 32'h200, 32'h000080FF);
    do_load("lb0", 3'b000, 32'h200, 32'h80FF1234, 5'd0, 32'h200, 32'h00000034);

    do_store("sb", 3'b000, 32'h41, 32'h000000AB, 32'h40, 4'b0010, 32'hABABABAB);
    do_store("sh", 3'b001, 32'h42, 32'h0000CAFE, 32'h40, 4'b1100, 32'hCAFECAFE);
    do_store("sw", 3'b010, 32'h44, 32'h12345678, 32'h44, 4'b1111, 32'h12345678);

    do_err("lw_mis", 1'b0, 3'b010, 32'h102);
    do_err("f3_011", 1'b0, 3'b011, 32'h100);
    do_err("sh_mis", 1'b1, 3'b001, 32'h43);

    // Stray ack while idle must not start anything.
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    mid();
    chk("idle_ack_req", bus_req, 0);
    chk("idle_ack_frz", freeze_o, 0);

    // Timeout: no ack ever.
    req_cycles = 0; err_pulses = 0; rw_seen = 0;
    tick();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300; rd_i = 5'd3; reg_write_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      mem_read = 1'b0;
      mid();
      if (bus_req) req_cycles++;
      if (bus_err_o) err_pulses++;
      if (reg_write) rw_seen++;
    end
    chk("tmo_req_cycles", req_cycles, 16);
    chk("tmo_err_pulses", err_pulses, 1);
    chk("tmo_no_rw", rw_seen, 0);
    chk("tmo_frz_idle", freeze_o, 0);

    // Reset in the middle of BUSY.
    tick();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400; rd_i = 5'd4; reg_write_i = 1'b0;
    tick();
    mem_read = 1'b0;
    mid();
    chk("rstm_req_before", bus_req, 1);
    rst = 1'b1;
    #1;
    chk("rstm_req_now", bus_req, 0);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    tick();
    rst = 1'b0; bus_ack = 1'b0;
    mid();
    chk("rstm_rw1", reg_write, 0);
    chk("rstm_frz", freeze_o, 0);
    tick();
    mid();
    chk("rstm_rw2", reg_write, 0);
    tick();
    alu_result = 32'h1234; reg_write_i = 1'b1; rd_i = 5'd7;
    mid();
    chk("pass_wdata", write_data, 32'h1234);
    chk("pass_rw", reg_write, 1);
    chk("pass_wreg", write_reg, 5'd7);
    chk("pass_frz", freeze_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/t07_memory_handler.md
Name: t07_memory_handler

Overview:
- Load/store stage directly upstream of the register file write port.
- Converts control-unit memory requests into a single-outstanding data-bus transaction: byte-lane steering, alignment checking, and sign/zero extension.
- Produces write_data / reg_write / write_reg for register writeback.
- Drives freeze_o so the rest of the datapath stalls while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles to wait for bus_ack before aborting (1..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  control: current instruction is a load.
- mem_write  in  1  control: current instruction is a store.
- funct3  in  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; all others illegal.
- addr  in  32  effective byte address (ALU result).
- store_data  in  32  rs2 value for stores.
- alu_result  in  32  writeback value for non-memory instructions.
- reg_write_i  in  1  control: instruction writes rd.
- rd_i  in  5  destination register index.
- bus_req  out  1  bus request, held until ack.
- bus_we  out  1  1 = store.
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_wdata  out  32  lane-replicated store data.
- bus_strb  out  4  byte enables.
- bus_ack  in  1  bus completion; bus_rdata is valid in the same cycle.
- bus_rdata  in  32  load word.
- write_data  out  32  to register file.
- reg_write  out  1  to register file write enable.
- write_reg  out  5  to register file write index.
- freeze_o  out  1  stall to rest of datapath.
- access_err_o  out  1  one-cycle pulse: misaligned or illegal funct3.
- bus_err_o  out  1  one-cycle pulse: timeout abort.

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, bus_strb = 0.
  - Load result register = 0, timeout counter = 0.
  - access_err_o = 0, bus_err_o = 0.
  - Reset mid-transaction abandons the transaction; no writeback occurs.
- States: IDLE, BUSY, DONE.
- IDLE, no memory op (mem_read = mem_write = 0):
  - Combinational pass-through: write_data = alu_result, reg_write = reg_write_i, write_reg = rd_i.
  - freeze_o = 0.
- IDLE, mem_read or mem_write (mem_read has priority if both are set):
  - Illegal funct3 or misalignment (halfword addr[0] != 0; word addr[1:0] != 0): access_err_o pulses next cycle, no bus request, reg_write = 0, freeze_o = 0, stay in IDLE.
  - Otherwise: freeze_o = 1 combinationally this cycle, reg_write = 0.
  - Latch addr, funct3, rd_i, direction and store data.
  - Go to BUSY; timeout counter = 0.
- BUSY:
  - bus_req = 1, freeze_o = 1, reg_write = 0.
  - All bus outputs are held stable from registered values.
  - Store lanes:
    - SB: strb = 0001 << addr[1:0], wdata = {4{store_data[7:0]}}.
    - SH: strb = 0011 if addr[1] = 0, else 1100; wdata = {2{store_data[15:0]}}.
    - SW: strb = 1111, wdata = store_data.
  - Loads: bus_we = 0, strb = 1111.
  - bus_ack = 1 (may arrive in the first BUSY cycle):
    - bus_req deasserts next cycle.
    - Loads: select the byte/half lane by the latched addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), register the result.
    - Go to DONE.
  - No ack: counter increments. At counter == TIMEOUT_CYCLES-1 without ack: bus_err_o pulses, go to IDLE with no writeback (freeze_o drops next cycle).
- DONE (exactly one cycle):
  - freeze_o = 0, write_reg = latched rd.
  - Loads: write_data = extended result, reg_write = 1.
  - Stores: reg_write = 0.
  - Return to IDLE; new requests are not accepted in DONE.
- Other rules:
  - bus_ack while IDLE or DONE is ignored.
  - mem_read/mem_write changes during BUSY are ignored.
  - rd = 0 is passed through unchanged; the register file discards the write.

Test Plan:
- LW addr=0x100, bus_ack on 2nd BUSY cycle, rdata=0xDEADBEEF, rd=5 -> bus_addr=0x100, strb=1111, freeze high 3 cycles, DONE: write_data=0xDEADBEEF, reg_write=1, write_reg=5.
- LB addr=0x203, rdata=0x80FF1234 -> write_data=0xFFFFFF80; repeat with LBU -> 0x00000080; LH addr=0x202 -> 0xFFFF80FF.
- SB addr=0x41, store_data=0x000000AB -> bus_we=1, strb=0010, wdata=0xABABABAB, reg_write stays 0; SH addr=0x42 -> strb=1100.
- LW addr=0x102 -> access_err_o one-cycle pulse, bus_req never rises, freeze_o=0; funct3=011 -> same response.
- No ack with TIMEOUT_CYCLES=16 -> bus_req high exactly 16 cycles, bus_err_o pulses once, no reg_write, back to IDLE.
- rst asserted mid-BUSY -> bus_req=0 immediately, no writeback after release; next non-memory op with alu_result=0x1234, reg_write_i=1 passes through the same cycle.
